// File: rtl/count_disp_pkg.sv
// Shared constants and types for the count_display block.
// Segment codes are gfedcba, active-high.
package count_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] BCD_TEN   = 4'd10;
    localparam logic [3:0] CNT_MAX   = 4'd15;

    typedef enum logic {
        DIG_ONES = 1'b0,
        DIG_TENS = 1'b1
    } mux_state_e;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/count_display_seg7_encode.sv
// Combinational BCD digit to 7-segment encoder.
// Non-decimal codes 10..15 drive a dark digit.
module seg7_encode
    import count_disp_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    assign seg_o = seg_code(digit_i);

endmodule

// File: rtl/count_display.sv
// Two-digit multiplexed 7-segment display of a 4-bit count with wrap detection.
// Define LEAD_ZERO_BLANK_EN to darken a leading zero in the tens digit.
module count_display
    import count_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 1000,
    parameter int WRAP_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        cnt_in,
    output logic [6:0]        seg,
    output logic [1:0]        an,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

    logic [3:0]        cnt_q;
    logic [3:0]        cnt_prev_q;
    logic              tens_q;
    logic              tens_d;
    logic [3:0]        ones_q;
    logic [3:0]        ones_d;
    mux_state_e        state_q;
    mux_state_e        state_d;
    logic [REF_W-1:0]  refresh_q;
    logic [REF_W-1:0]  refresh_d;
    logic [6:0]        seg_q;
    logic [6:0]        seg_d;
    logic [1:0]        an_q;
    logic [1:0]        an_d;
    logic              wrap_pulse_q;
    logic [WRAP_W-1:0] wrap_cnt_q;
    logic [WRAP_W-1:0] wrap_cnt_d;
    logic              wrap_hit;
    logic [3:0]        digit;
    logic              blank;
    logic [6:0]        enc_seg;

    // Decimal split uses the freshly compared tens, not last cycle's.
    always_comb begin
        tens_d = (cnt_q >= BCD_TEN);
        ones_d = tens_d ? (cnt_q - BCD_TEN) : cnt_q;
    end

    always_comb begin
        state_d   = state_q;
        refresh_d = refresh_q + 1'b1;
        if (refresh_q == REF_LAST) begin
            refresh_d = '0;
            state_d   = (state_q == DIG_ONES) ? DIG_TENS : DIG_ONES;
        end
    end

    always_comb begin
        digit = ones_q;
        blank = 1'b0;
        an_d  = 2'b01;
        unique case (state_q)
            DIG_ONES: begin
                digit = ones_q;
                an_d  = 2'b01;
            end
            DIG_TENS: begin
                digit = {3'b000, tens_q};
                an_d  = 2'b10;
`ifdef LEAD_ZERO_BLANK_EN
                blank = ~tens_q;
`else
                blank = 1'b0;
`endif
            end
        endcase
    end

    seg7_encode u_enc (
        .digit_i (digit),
        .seg_o   (enc_seg)
    );

    always_comb begin
        seg_d      = blank ? SEG_BLANK : enc_seg;
        wrap_hit   = (cnt_prev_q == CNT_MAX) && (cnt_q == 4'd0);
        wrap_cnt_d = wrap_cnt_q;
        if (wrap_hit) begin
            wrap_cnt_d = wrap_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= 4'd0;
            cnt_prev_q   <= 4'd0;
            tens_q       <= 1'b0;
            ones_q       <= 4'd0;
            state_q      <= DIG_ONES;
            refresh_q    <= '0;
            seg_q        <= SEG_BLANK;
            an_q         <= 2'b00;
            wrap_pulse_q <= 1'b0;
            wrap_cnt_q   <= '0;
        end else begin
            cnt_q        <= cnt_in;
            cnt_prev_q   <= cnt_q;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            state_q      <= state_d;
            refresh_q    <= refresh_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            wrap_pulse_q <= wrap_hit;
            wrap_cnt_q   <= wrap_cnt_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign wrap_pulse = wrap_pulse_q;
    assign wrap_cnt   = wrap_cnt_q;

endmodule

// File: tb/tb_count_display.sv
// Directed self-checking bench for count_display.
// Covers digit muxing, BCD split, wrap detection and async reset.
module tb_count_display;

    localparam logic [6:0] S0 = 7'b0111111;
    localparam logic [6:0] S1 = 7'b0000110;
    localparam logic [6:0] S3 = 7'b1001111;
    localparam logic [6:0] S7 = 7'b0000111;
`ifdef LEAD_ZERO_BLANK_EN
    localparam logic [6:0] TENS0 = 7'b0000000;
`else
    localparam logic [6:0] TENS0 = 7'b0111111;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cnt_in = 4'd0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       wrap_pulse;
    logic [7:0] wrap_cnt;
    logic [6:0] seg2;
    logic [1:0] an2;
    logic       wp2;
    logic [1:0] wc2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    count_display #(.REFRESH_DIV(4), .WRAP_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .seg        (seg),
        .an         (an),
        .wrap_pulse (wrap_pulse),
        .wrap_cnt   (wrap_cnt)
    );

    count_display #(.REFRESH_DIV(1), .WRAP_W(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .seg        (seg2),
        .an         (an2),
        .wrap_pulse (wp2),
        .wrap_cnt   (wc2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int seq [18];
        logic [1:0] exp2 [5];
        bit found;
        exp2 = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2};

        #2 rst = 1'b0;
        #1;
        chk("rst_seg", seg, 7'd0);
        chk("rst_an", an, 2'b00);
        chk("rst_wp", wrap_pulse, 1'b0);
        chk("rst_wc", wrap_cnt, 8'd0);

        cnt_in = 4'd7;
        step(2);
        @(negedge clk) rst = 1'b1;

        step(1);
        chk("e1_an", an, 2'b01);
        chk("d2_e1_an", an2, 2'b01);
        step(1);
        chk("d2_e2_an", an2, 2'b10);
        step(1);
        chk("e3_seg7", seg, S7);
        chk("e3_an", an, 2'b01);
        chk("d2_e3_seg7", seg2, S7);
        chk("d2_e3_an", an2, 2'b01);
        step(1);
        chk("e4_an", an, 2'b01);
        chk("d2_e4_seg", seg2, TENS0);
        chk("d2_e4_an", an2, 2'b10);
        step(1);
        chk("e5_an", an, 2'b10);
        chk("e5_seg_tens0", seg, TENS0);

        cnt_in = 4'd13;
        step(3);
        chk("e8_an", an, 2'b10);
        chk("e8_seg1", seg, S1);
        step(1);
        chk("e9_an", an, 2'b01);
        chk("e9_seg3", seg, S3);
        step(3);
        chk("e12_an", an, 2'b01);
        step(1);
        chk("e13_an", an, 2'b10);
        chk("e13_seg1", seg, S1);

        for (int i = 0; i < 18; i++) seq[i] = (i < 16) ? i : i - 16;
        for (int i = 0; i < 18; i++) begin
            cnt_in = 4'(seq[i]);
            step(1);
            chk($sformatf("ramp_wp_%0d", i), wrap_pulse, (i == 17));
            chk($sformatf("d2_ramp_wp_%0d", i), wp2, (i == 17));
        end
        step(1);
        chk("ramp_wp_after", wrap_pulse, 1'b0);
        chk("ramp_wc", wrap_cnt, 8'd1);
        chk("d2_ramp_wc", wc2, 2'd1);

        seq[0] = 5; seq[1] = 6; seq[2] = 7;
        seq[3] = 0; seq[4] = 0; seq[5] = 1;
        for (int i = 0; i < 6; i++) begin
            cnt_in = 4'(seq[i]);
            step(1);
            chk($sformatf("ureset_wp_%0d", i), wrap_pulse, 1'b0);
        end
        step(2);
        chk("ureset_wp_tail", wrap_pulse, 1'b0);
        chk("ureset_wc", wrap_cnt, 8'd1);

        cnt_in = 4'd15;
        step(3);
        chk("hold15_wp", wrap_pulse, 1'b0);

        for (int r = 0; r < 5; r++) begin
            for (int v = 1; v < 16; v++) begin
                cnt_in = 4'(v);
                step(1);
            end
            cnt_in = 4'd0;
            step(2);
            chk($sformatf("roll_wp_%0d", r), wp2, 1'b1);
            chk($sformatf("roll_wc2_%0d", r), wc2, exp2[r]);
        end
        chk("roll_wc8", wrap_cnt, 8'd6);

        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (an == 2'b10) found = 1'b1;
            else step(1);
        end
        chk("find_tens_window", found, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("arst_seg", seg, 7'd0);
        chk("arst_an", an, 2'b00);
        chk("arst_wc", wrap_cnt, 8'd0);
        chk("arst_wc2", wc2, 2'd0);
        @(negedge clk) rst = 1'b1;
        step(1);
        chk("rel_an", an, 2'b01);
        chk("rel_wp", wrap_pulse, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_display.md
Name: count_display

Overview:
Downstream consumer of the 4-bit free-running up-counter (0..15).
- Registers the count value and converts it to two decimal digits (00..15).
- Time-multiplexes the two digits onto a 2-digit common 7-segment display.
- Detects the 15->0 wrap-around, emitting a one-cycle pulse and maintaining a wrap tally.
- Sits between the counter output and the board's display pins.

Parameters:
REFRESH_DIV, 1000, clock cycles each digit stays enabled before the mux switches; legal range >= 1.
WRAP_W, 8, width of the wrap tally counter.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous reset, active-low (0 = reset asserted)
cnt_in  in  4  count value from the up-counter, sampled every cycle
seg  out  7  segment drives, active-high, seg[0]=a ... seg[6]=g
an  out  2  digit enables, one-hot active-high; an[0]=ones, an[1]=tens
wrap_pulse  out  1  one-cycle pulse on a 15->0 transition of the sampled count
wrap_cnt  out  WRAP_W  number of wraps since reset, modulo 2^WRAP_W

Behaviour:
Reset (rst=0, asynchronous, any time):
- seg=0, an=2'b00, wrap_pulse=0, wrap_cnt=0.
- Internal cnt_q=0, cnt_prev=0, tens=0, ones=0.
- Mux state=DIG_ONES, refresh counter=0.
- Reset mid-refresh or mid-wrap aborts everything; there is no partial state.

Stage 1, capture:
- cnt_q <= cnt_in; cnt_prev <= cnt_q, every cycle.

Stage 2, BCD:
- tens <= (cnt_q >= 10) ? 1 : 0; ones <= cnt_q - (tens ? 10 : 0).
- tens is only ever 0 or 1; ones is 0..9.

Stage 3, output:
- seg/an are registered from the current mux state and the stage-2 digits.
- Latency cnt_in -> seg is 3 cycles when the corresponding digit is selected.

Mux FSM, two states DIG_ONES and DIG_TENS:
- The refresh counter counts 0..REFRESH_DIV-1.
- At REFRESH_DIV-1 the counter returns to 0 and the state toggles.
- an = 2'b01 in DIG_ONES, 2'b10 in DIG_TENS; never both set.
- REFRESH_DIV=1: state toggles every cycle.
- First cycle after reset release: an=2'b01 showing ones.

Segment codes, gfedcba (active-high):
- 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
- 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111

Wrap detection:
- wrap_pulse <= (cnt_prev==15 && cnt_q==0), asserted for exactly 1 cycle.
- The same cycle it asserts, wrap_cnt increments, rolling over from 2^WRAP_W-1 to 0.
- Any other discontinuity (e.g. counter synchronously reset from 7->0) is not a wrap.
- A held value (0->0, 15->15) is not a wrap.
- 0->0 immediately after reset produces no pulse.

Optional Feature:
LEAD_ZERO_BLANK_EN
- Defined: in DIG_TENS with tens==0, seg=7'b0000000 (digit dark); an still 2'b10.
- Undefined: the tens digit always shows, i.e. "0" for values 0..9.

Decomposition:
Package count_disp_pkg:
- SEG_0..SEG_9 and SEG_BLANK constants.
- Mux state typedef {DIG_ONES, DIG_TENS}.
- BCD_TEN=4'd10.

Sub-module seg7_encode:
- Combinational 4-bit digit to 7-bit segment code.
- Codes 10..15 map to SEG_BLANK.
- Instantiated once, fed from a digit select in count_display.

Test Plan:
- Reset then cnt_in=4'd7 held, REFRESH_DIV=4 -> after 3 cycles seg=0000111 while an=01; in the an=10 window seg=0111111 (or 0 with LEAD_ZERO_BLANK_EN).
- cnt_in=4'd13 held -> an=01 shows 1001111 ("3"), an=10 shows 0000110 ("1"); an alternates every 4 cycles.
- cnt_in ramps 0..15,0,1 one per cycle -> exactly one wrap_pulse, 2 cycles after cnt_in=0 is applied; wrap_cnt 0->1.
- cnt_in sequence 5,6,7,0,1 (upstream reset) -> no wrap_pulse, wrap_cnt unchanged.
- WRAP_W=2, 5 full ramps -> wrap_cnt sequence 1,2,3,0,1.
- Assert rst=0 asynchronously mid-window with an=10 -> seg=0, an=00, wrap_cnt=0 without a clock edge; after release an=01 first.
